// File: rtl/seed_host_if.sv
// -----------------------------------------------------------------------------
// seed_host_if
// Word-addressed host register interface in front of a SEED block cipher core.
// The host loads a 128-bit key and a 128-bit block as four 32-bit words, then
// writes CTRL to start a key schedule, a block operation, or both back-to-back.
// A small FSM issues one-cycle load strobes to the core, waits for the core
// with a bounded counter, and captures the result into DOUT.
//
// Ports
//   clk             single clock, rising edge
//   nreset          asynchronous active-low reset
//   wr_en, rd_en    host word write / read strobes
//   addr [3:0]      host word address
//   wdata [31:0]    host write data
//   rdata [31:0]    host read data, registered, valid one cycle after rd_en
//   core_data_in    key or block presented to the core during an ISSUE state
//   core_key_rdy    one-cycle key load strobe
//   core_data_rdy   one-cycle block load strobe
//   core_EncDec     operation mode to the core (1 = decrypt)
//   core_data_out   result block from the core
//   core_data_valid result valid from the core
//   core_key_valid  key schedule complete from the core
//   core_busy       core busy flag
// -----------------------------------------------------------------------------
module seed_host_if #(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         wr_en,
  input  logic         rd_en,
  input  logic [3:0]   addr,
  input  logic [31:0]  wdata,
  output logic [31:0]  rdata,
  output logic [127:0] core_data_in,
  output logic         core_key_rdy,
  output logic         core_data_rdy,
  output logic         core_EncDec,
  input  logic [127:0] core_data_out,
  input  logic         core_data_valid,
  input  logic         core_key_valid,
  input  logic         core_busy
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    KEY_ISSUE  = 3'd1,
    KEY_WAIT   = 3'd2,
    DATA_ISSUE = 3'd3,
    DATA_WAIT  = 3'd4
  } state_t;

  // Counter value at which the next wait cycle would reach TIMEOUT.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t         state_r;
  logic [127:0]   key_r;
  logic [127:0]   din_r;
  logic [127:0]   dout_r;
  logic           key_ok_r;
  logic           done_r;
  logic           err_r;
  logic           pend_data_r;
  logic [7:0]     cnt_r;

  logic           active_s;
  logic           wr_host_reg_s;
  logic           rd_status_s;
  logic [31:0]    status_s;
  logic [31:0]    rd_mux_s;

  assign active_s      = (state_r != IDLE);
  assign wr_host_reg_s = wr_en && ((addr[3] == 1'b0) || (addr == 4'h8));
  assign rd_status_s   = rd_en && (addr == 4'h9);
  assign status_s      = {28'd0, err_r, active_s, done_r, key_ok_r};

  // Host read data selection from the address map.
  always_comb begin
    rd_mux_s = 32'd0;
    case (addr)
      4'h0:    rd_mux_s = key_r[127:96];
      4'h1:    rd_mux_s = key_r[95:64];
      4'h2:    rd_mux_s = key_r[63:32];
      4'h3:    rd_mux_s = key_r[31:0];
      4'h4:    rd_mux_s = din_r[127:96];
      4'h5:    rd_mux_s = din_r[95:64];
      4'h6:    rd_mux_s = din_r[63:32];
      4'h7:    rd_mux_s = din_r[31:0];
      4'h9:    rd_mux_s = status_s;
      4'hC:    rd_mux_s = dout_r[127:96];
      4'hD:    rd_mux_s = dout_r[95:64];
      4'hE:    rd_mux_s = dout_r[63:32];
      4'hF:    rd_mux_s = dout_r[31:0];
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Host registers, status flags, control FSM and registered core outputs.
  // Later non-blocking assignments override earlier ones, so flag set events
  // written after the STATUS-read clear take priority over it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r       <= IDLE;
      key_r         <= 128'd0;
      din_r         <= 128'd0;
      dout_r        <= 128'd0;
      key_ok_r      <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      pend_data_r   <= 1'b0;
      cnt_r         <= 8'd0;
      rdata         <= 32'd0;
      core_data_in  <= 128'd0;
      core_key_rdy  <= 1'b0;
      core_data_rdy <= 1'b0;
      core_EncDec   <= 1'b0;
    end else begin
      if (rd_en) begin
        rdata <= rd_mux_s;
      end else begin
        rdata <= rdata;
      end

      if (rd_status_s) begin
        done_r <= 1'b0;
        err_r  <= 1'b0;
      end else begin
        done_r <= done_r;
        err_r  <= err_r;
      end

      // KEY/DIN are only writable while idle; any host write while active
      // is dropped and flagged.
      if (wr_host_reg_s && active_s) begin
        err_r <= 1'b1;
      end else if (wr_en) begin
        case (addr)
          4'h0:    key_r[127:96] <= wdata;
          4'h1:    key_r[95:64]  <= wdata;
          4'h2:    key_r[63:32]  <= wdata;
          4'h3:    key_r[31:0]   <= wdata;
          4'h4:    din_r[127:96] <= wdata;
          4'h5:    din_r[95:64]  <= wdata;
          4'h6:    din_r[63:32]  <= wdata;
          4'h7:    din_r[31:0]   <= wdata;
          default: key_r         <= key_r;
        endcase
      end else begin
        key_r <= key_r;
      end

      case (state_r)
        IDLE: begin
          if (wr_en && (addr == 4'h8)) begin
            if (wdata[0]) begin
              core_EncDec  <= wdata[2];
              key_ok_r     <= 1'b0;
              pend_data_r  <= wdata[1];
              core_data_in <= key_r;
              core_key_rdy <= 1'b1;
              state_r      <= KEY_ISSUE;
            end else if (wdata[1]) begin
              if (key_ok_r) begin
                core_data_in  <= din_r;
                core_data_rdy <= 1'b1;
                state_r       <= DATA_ISSUE;
              end else begin
                err_r <= 1'b1;
              end
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        KEY_ISSUE: begin
          core_key_rdy <= 1'b0;
          core_data_in <= 128'd0;
          cnt_r        <= 8'd0;
          state_r      <= KEY_WAIT;
        end

        KEY_WAIT: begin
          // cnt_r == 0 is the entry cycle, where the core's flags may still
          // reflect a previous key and are not trusted.
          if ((cnt_r != 8'd0) && core_key_valid && !core_busy) begin
            key_ok_r <= 1'b1;
            if (pend_data_r) begin
              pend_data_r   <= 1'b0;
              core_data_in  <= din_r;
              core_data_rdy <= 1'b1;
              state_r       <= DATA_ISSUE;
            end else begin
              state_r <= IDLE;
            end
          end else if (cnt_r == LAST_CNT) begin
            err_r       <= 1'b1;
            pend_data_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end

        DATA_ISSUE: begin
          core_data_rdy <= 1'b0;
          core_data_in  <= 128'd0;
          done_r        <= 1'b0;
          cnt_r         <= 8'd0;
          state_r       <= DATA_WAIT;
        end

        DATA_WAIT: begin
          if (core_data_valid) begin
            dout_r  <= core_data_out;
            done_r  <= 1'b1;
            state_r <= IDLE;
          end else if (cnt_r == LAST_CNT) begin
            err_r   <= 1'b1;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end

        default: begin
          core_key_rdy  <= 1'b0;
          core_data_rdy <= 1'b0;
          core_data_in  <= 128'd0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seed_host_if.sv
// -----------------------------------------------------------------------------
// tb_seed_host_if
// Directed bench for seed_host_if with a small behavioural SEED core stand-in.
// The stand-in "cipher" is a word swap XOR key XOR mode mask, so results can
// be worked out by hand.
// -----------------------------------------------------------------------------
module tb_seed_host_if;

  logic         clk;
  logic         nreset;
  logic         wr_en;
  logic         rd_en;
  logic [3:0]   addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic [127:0] core_data_in;
  logic         core_key_rdy;
  logic         core_data_rdy;
  logic         core_EncDec;
  logic [127:0] core_data_out;
  logic         core_data_valid;
  logic         core_key_valid;
  logic         core_busy;

  int total;
  int bad;
  int key_pulses;
  int data_pulses;
  int overlap;
  logic enc_at_rdy;
  logic no_valid;

  // Expected results worked out by hand:
  // enc of DIN1 with key 0 = word-swapped DIN1.
  localparam logic [127:0] DIN1 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] EXP1 = 128'h8899aabb_ccddeeff_00112233_44556677;
  localparam logic [127:0] DIN2 = 128'hc9c6296f_9dbfdc1d_284a3dfa_4683581a;
  localparam logic [127:0] EXP2 = 128'hd7b5c205_b97ca7e5_3639d690_624023e2;

  seed_host_if #(.TIMEOUT(255)) dut (
    .clk             (clk),
    .nreset          (nreset),
    .wr_en           (wr_en),
    .rd_en           (rd_en),
    .addr            (addr),
    .wdata           (wdata),
    .rdata           (rdata),
    .core_data_in    (core_data_in),
    .core_key_rdy    (core_key_rdy),
    .core_data_rdy   (core_data_rdy),
    .core_EncDec     (core_EncDec),
    .core_data_out   (core_data_out),
    .core_data_valid (core_data_valid),
    .core_key_valid  (core_key_valid),
    .core_busy       (core_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural core: key takes 3 cycles, block takes 5 cycles.
  logic [127:0] m_key;
  logic [127:0] m_blk;
  logic         m_mode;
  logic [3:0]   m_kcnt;
  logic [3:0]   m_dcnt;

  function automatic logic [127:0] core_f(input logic [127:0] b, input logic [127:0] k, input logic m);
    core_f = {b[63:0], b[127:64]} ^ k ^ {128{m}};
  endfunction

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_key <= 128'd0; m_blk <= 128'd0; m_mode <= 1'b0;
      m_kcnt <= 4'd0; m_dcnt <= 4'd0;
      core_busy <= 1'b0; core_key_valid <= 1'b0;
      core_data_valid <= 1'b0; core_data_out <= 128'd0;
    end else begin
      core_data_valid <= 1'b0;
      if (core_key_rdy) begin
        m_key <= core_data_in; core_key_valid <= 1'b0;
        core_busy <= 1'b1; m_kcnt <= 4'd3;
      end else if (m_kcnt != 4'd0) begin
        m_kcnt <= m_kcnt - 4'd1;
        if (m_kcnt == 4'd1) begin
          core_busy <= 1'b0; core_key_valid <= 1'b1;
        end
      end
      if (core_data_rdy) begin
        m_blk <= core_data_in; m_mode <= core_EncDec;
        core_busy <= 1'b1; m_dcnt <= 4'd5;
      end else if (m_dcnt != 4'd0) begin
        m_dcnt <= m_dcnt - 4'd1;
        if (m_dcnt == 4'd1 && !no_valid) begin
          core_busy <= 1'b0; core_data_valid <= 1'b1;
          core_data_out <= core_f(m_blk, m_key, m_mode);
        end
      end
    end
  end

  // Strobe monitor.
  always @(posedge clk) begin
    if (core_key_rdy) key_pulses++;
    if (core_data_rdy) begin
      data_pulses++;
      enc_at_rdy = core_EncDec;
    end
    if (core_key_rdy && core_data_rdy) overlap++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    tick();
    wr_en = 1'b0; wdata = 32'd0;
  endtask

  task automatic host_read(input logic [3:0] a, output logic [31:0] d);
    rd_en = 1'b1; addr = a;
    tick();
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic write_block(input logic [3:0] base, input logic [127:0] v);
    for (int i = 0; i < 4; i++) host_write(base + 4'(i), v[127 - 32*i -: 32]);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    nreset = 1'b0; no_valid = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; addr = 4'd0; wdata = 32'd0;
    tick(); tick();
    nreset = 1'b1;
    tick();
    key_pulses = 0; data_pulses = 0; enc_at_rdy = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    @(posedge clk); #1;
    nreset = 1'b0;
    #2;
    total++;
    if ({rdata, core_key_rdy, core_data_rdy, core_EncDec} !== 35'd0 || core_data_in !== 128'd0) begin
      bad++; $display("FAIL reset_outputs: rdata=%h strobes=%b%b%b din=%h want all 0", rdata, core_key_rdy, core_data_rdy, core_EncDec, core_data_in);
    end
    do_reset();
    host_read(4'h9, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_status: got %h want 0", d); end
    host_read(4'hC, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_dout: got %h want 0", d); end
  endtask

  task automatic check_dout(input string nm, input logic [127:0] exp);
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      host_read(4'hC + 4'(i), d);
      total++;
      if (d !== exp[127 - 32*i -: 32]) begin
        bad++; $display("FAIL %s word%0d: got %h want %h", nm, i, d, exp[127 - 32*i -: 32]);
      end
    end
  endtask

  task automatic test_key_data();
    logic [31:0] d;
    do_reset();
    write_block(4'h0, 128'd0);
    write_block(4'h4, DIN1);
    host_write(4'h8, 32'h3);
    repeat (40) tick();
    total++;
    if (key_pulses !== 1) begin bad++; $display("FAIL kd_key_pulses: got %0d want 1", key_pulses); end
    total++;
    if (data_pulses !== 1) begin bad++; $display("FAIL kd_data_pulses: got %0d want 1", data_pulses); end
    check_dout("kd_dout", EXP1);
    host_read(4'h9, d);
    total++;
    if (d !== 32'h3) begin bad++; $display("FAIL kd_status: got %h want 3", d); end
    host_read(4'h9, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL kd_status_clr: got %h want 1", d); end
    host_read(4'hA, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL kd_unmapped: got %h want 0", d); end
  endtask

  task automatic test_no_key();
    logic [31:0] d;
    do_reset();
    host_write(4'h8, 32'h2);
    repeat (10) tick();
    total++;
    if (data_pulses !== 0) begin bad++; $display("FAIL nokey_data_pulses: got %0d want 0", data_pulses); end
    host_read(4'h9, d);
    total++;
    if (d !== 32'h8) begin bad++; $display("FAIL nokey_status: got %h want 8", d); end
    host_read(4'h9, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL nokey_status_clr: got %h want 0", d); end
  endtask

  task automatic test_decrypt();
    logic [31:0] d;
    do_reset();
    host_write(4'h8, 32'h5);
    repeat (20) tick();
    write_block(4'h4, DIN2);
    host_write(4'h8, 32'h2);
    repeat (40) tick();
    total++;
    if (data_pulses !== 1 || enc_at_rdy !== 1'b1) begin
      bad++; $display("FAIL dec_mode: pulses=%0d encdec=%b want 1 and 1", data_pulses, enc_at_rdy);
    end
    check_dout("dec_dout", EXP2);
    host_read(4'h9, d);
    total++;
    if (d !== 32'h3) begin bad++; $display("FAIL dec_status: got %h want 3", d); end
  endtask

  task automatic wait_data_rdy(input string nm);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (core_data_rdy) found = 1'b1;
      else tick();
    end
    total++;
    if (found !== 1'b1) begin bad++; $display("FAIL %s: data_rdy seen=%b want 1", nm, found); end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    do_reset();
    write_block(4'h4, DIN1);
    host_write(4'h8, 32'h3);
    repeat (40) tick();
    host_read(4'h9, d);
    total++;
    if (d !== 32'h3) begin bad++; $display("FAIL to_prep_status: got %h want 3", d); end
    no_valid = 1'b1;
    host_write(4'h8, 32'h2);
    wait_data_rdy("to_wait_rdy");
    // DATA_WAIT is entered on the next edge; err must appear 255 edges later.
    repeat (255) tick();
    rd_en = 1'b1; addr = 4'h9;
    tick();
    total++;
    if (rdata !== 32'h5) begin bad++; $display("FAIL to_before: got %h want 5", rdata); end
    tick();
    rd_en = 1'b0;
    total++;
    if (rdata !== 32'h9) begin bad++; $display("FAIL to_after: got %h want 9", rdata); end
    no_valid = 1'b0;
    check_dout("to_dout", EXP1);
  endtask

  task automatic test_din_busy();
    logic [31:0] d;
    do_reset();
    write_block(4'h4, DIN1);
    host_write(4'h8, 32'h3);
    wait_data_rdy("busy_wait_rdy");
    tick();
    host_write(4'h4, 32'hdeadbeef);
    repeat (30) tick();
    host_read(4'h4, d);
    total++;
    if (d !== 32'h00112233) begin bad++; $display("FAIL busy_din: got %h want 00112233", d); end
    host_read(4'h9, d);
    total++;
    if (d !== 32'hB) begin bad++; $display("FAIL busy_status: got %h want b", d); end
    check_dout("busy_dout", EXP1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic found;
    do_reset();
    host_write(4'h8, 32'h5);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (core_key_rdy) found = 1'b1;
      else tick();
    end
    total++;
    if (found !== 1'b1) begin bad++; $display("FAIL mid_key_rdy: seen=%b want 1", found); end
    host_read(4'h9, d);
    total++;
    if (d !== 32'h4) begin bad++; $display("FAIL mid_active: got %h want 4", d); end
    #2;
    nreset = 1'b0;
    #1;
    total++;
    if ({rdata, core_key_rdy, core_data_rdy, core_EncDec} !== 35'd0 || core_data_in !== 128'd0) begin
      bad++; $display("FAIL mid_reset_outputs: rdata=%h strobes=%b%b%b din=%h want all 0", rdata, core_key_rdy, core_data_rdy, core_EncDec, core_data_in);
    end
    tick(); tick();
    nreset = 1'b1;
    tick();
    key_pulses = 0; data_pulses = 0;
    host_write(4'h8, 32'h2);
    repeat (10) tick();
    total++;
    if (key_pulses !== 0 || data_pulses !== 0) begin
      bad++; $display("FAIL mid_pulses: key=%0d data=%0d want 0 0", key_pulses, data_pulses);
    end
    host_read(4'h9, d);
    total++;
    if (d !== 32'h8) begin bad++; $display("FAIL mid_status: got %h want 8", d); end
  endtask

  initial begin
    total = 0; bad = 0; overlap = 0;
    key_pulses = 0; data_pulses = 0; enc_at_rdy = 1'b0; no_valid = 1'b0;
    nreset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = 4'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    test_reset();
    test_key_data();
    test_no_key();
    test_decrypt();
    test_timeout();
    test_din_busy();
    test_reset_mid();
    total++;
    if (overlap !== 0) begin bad++; $display("FAIL strobe_overlap: got %0d want 0", overlap); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
